// File: rtl/spike_rle_encoder.sv
// Run-length encodes a 1-bit spike train into 8-bit {type, gap} event words held in a small FIFO.
// Latency: a word pushed on edge N is at the head after edge N when the FIFO was empty.
// Backpressure: out_ready low holds the head word; a push into a full FIFO with no pop is dropped and sets overflow.
module spike_rle_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_W      = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       spike,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] fifo_level,
    output logic       overflow
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [3:0]      LVL_MAX = 4'(FIFO_DEPTH);
    // One below all-ones: the sample that would reach all-ones emits a saturation marker instead.
    localparam logic [GAP_W-1:0] GAP_SAT = {GAP_W{1'b1}} - 1'b1;

    logic [GAP_W-1:0] gap_q;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [3:0]       level_q;
    logic             ovf_q;

    logic             push_vld;
    logic [7:0]       push_dat;
    logic             pop;
    logic             full;
    logic             push_acc;

    // Decide whether this sample produces an event word and what it contains.
    always_comb begin
        push_vld = 1'b0;
        push_dat = 8'h00;
        if (en) begin
            if (spike) begin
                push_vld             = 1'b1;
                push_dat[7]          = 1'b1;
                push_dat[GAP_W-1:0]  = gap_q;
            end else if (gap_q == GAP_SAT) begin
                push_vld             = 1'b1;
                push_dat[GAP_W-1:0]  = {GAP_W{1'b1}};
            end
        end
    end

    assign out_valid  = (level_q != 4'd0);
    assign full       = (level_q == LVL_MAX);
    assign pop        = out_valid & out_ready;
    // A full FIFO still takes the word when the head leaves on the same edge.
    assign push_acc   = push_vld & (~full | pop);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

    // Silent-sample counter; cleared whenever a word is generated, even if it is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_q <= '0;
        end else if (en) begin
            if (spike || gap_q == GAP_SAT) begin
                gap_q <= '0;
            end else begin
                gap_q <= gap_q + 1'b1;
            end
        end
    end

    // Word storage; contents are don't-care while empty because out_data is masked.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; level alone tells full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 4'd0;
        end else begin
            if (push_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_acc, pop})
                2'b10:   level_q <= level_q + 4'd1;
                2'b01:   level_q <= level_q - 4'd1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (push_vld && !push_acc) begin
            ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spike_rle_encoder.sv
// Scoreboard bench for spike_rle_encoder: a reference model queues expected words on drive.
// Latency: words are compared at the handshake cycle the DUT presents them.
// Backpressure: out_ready is driven per cycle; the model tracks drops into a full FIFO.
module tb_spike_rle_encoder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       spike = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic [3:0] fifo_level;
    logic       overflow;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    int         m_gap = 0;
    bit         m_ovf = 1'b0;

    // Free-running clock.
    always #5 clk = ~clk;

    spike_rle_encoder #(.FIFO_DEPTH(DEPTH), .GAP_W(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike      (spike),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One sample: drive inputs, check DUT state against the model, advance the model, clock.
    task automatic cycle(input bit e, input bit s, input bit r);
        bit         pop;
        bit         full;
        bit         push;
        logic [7:0] w;
        en = e;
        spike = s;
        out_ready = r;
        #1;
        chk("valid", out_valid, exp_q.size() != 0);
        chk("level", fifo_level, exp_q.size());
        chk("ovf", overflow, m_ovf);
        full = (exp_q.size() == DEPTH);
        pop  = (exp_q.size() != 0) && r;
        if (pop) begin
            chk("data", out_data, exp_q[0]);
            void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            chk("idle_data", out_data, 0);
        end
        push = 1'b0;
        w = 8'h00;
        if (e) begin
            if (s) begin
                push = 1'b1;
                w = 8'h80 | 8'(m_gap);
                m_gap = 0;
            end else if (m_gap == 126) begin
                push = 1'b1;
                w = 8'h7F;
                m_gap = 0;
            end else begin
                m_gap++;
            end
        end
        if (push) begin
            if (!full || pop) exp_q.push_back(w);
            else m_ovf = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            en = 1'($urandom);
            spike = 1'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        en = 1'b0;
        spike = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        m_gap = 0;
        m_ovf = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
    endtask

    initial begin
        @(negedge clk);

        // Reset with random inputs.
        do_reset(2);

        // Three silent samples then a spike.
        for (int i = 0; i < 3; i++) cycle(1, 0, 1);
        cycle(1, 1, 1);
        chk("t2_word", out_data, 8'h83);
        chk("t2_valid", out_valid, 1);
        cycle(0, 0, 1);

        // Gap saturation marker and the largest non-saturated gap.
        do_reset(1);
        for (int i = 0; i < 127; i++) cycle(1, 0, 1);
        chk("t3_sat", out_data, 8'h7F);
        cycle(1, 1, 1);
        chk("t3_spk0", out_data, 8'h80);
        for (int i = 0; i < 126; i++) cycle(1, 0, 1);
        cycle(1, 1, 1);
        chk("t3_spk126", out_data, 8'hFE);
        cycle(0, 0, 1);

        // Overflow when full and stalled, then drain.
        do_reset(1);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0);
        chk("t4_level", fifo_level, 4);
        chk("t4_ovf", overflow, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);
        chk("t4_drained", fifo_level, 0);

        // Push into a full FIFO while popping.
        do_reset(1);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0);
        cycle(1, 1, 1);
        chk("t5_level", fifo_level, 4);
        chk("t5_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);

        // en gating: spikes on en=0 cycles are ignored.
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1'($urandom), 1);
            cycle(1, 0, 1);
        end
        cycle(0, 1, 1);
        cycle(1, 1, 1);
        chk("t6_word", out_data, 8'h86);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0);
        cycle(0, 0, 1);
        do_reset(1);
        cycle(0, 0, 1);

        // Random traffic with moderate spike rate and bursty readiness.
        do_reset(1);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
        // Sparse spikes so gaps reach saturation.
        for (int i = 0; i < 700; i++)
            cycle(1, $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
